// File: rtl/chiselwatt_reset_seq.sv
// ----------------------------------------------------------------------------
// chiselwatt_reset_seq
//
// Power-up reset sequencer for a PLL-clocked core. Runs on the free-running
// board reference clock (never the PLL output). The sequence is:
//   PLL_RST   : hold the PLL in reset for PLL_RST_CYCLES cycles
//   WAIT_LOCK : wait for the synchronized lock indicator
//   HOLD      : lock must stay high for HOLD_CYCLES consecutive cycles
//   RUN       : core out of reset; a lock loss re-resets the PLL, a soft
//               request re-enters HOLD without touching the PLL
//
// Ports:
//   clock         in   board reference clock
//   reset_n       in   asynchronous active-low reset
//   lock          in   PLL lock, asynchronous to clock
//   soft_rst_req  in   single-cycle request to re-reset only the core
//   pll_rst       out  active-high PLL reset
//   core_rst      out  active-high core reset (consumer re-synchronizes)
//   ready         out  high only in RUN, always ~core_rst
//   relock_count  out  saturating count of lock losses seen in RUN
//   state_dbg_o   out  current FSM state (debug visibility)
//
// Build option:
//   CHISELWATT_LOCK_TIMEOUT_EN - when defined, WAIT_LOCK gives up after
//   LOCK_TIMEOUT cycles without lock and resets the PLL again. When not
//   defined, WAIT_LOCK waits forever and LOCK_TIMEOUT does not size the
//   cycle counter.
// ----------------------------------------------------------------------------
module chiselwatt_reset_seq #(
    parameter int unsigned SYNC_STAGES    = 2,     // minimum 2
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned HOLD_CYCLES    = 1024,
    parameter int unsigned LOCK_TIMEOUT   = 65535
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       lock,
    input  logic       soft_rst_req,
    output logic       pll_rst,
    output logic       core_rst,
    output logic       ready,
    output logic [7:0] relock_count,
    output logic [1:0] state_dbg_o
);

    typedef enum logic [1:0] {
        S_PLL_RST   = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_HOLD      = 2'd2,
        S_RUN       = 2'd3
    } state_t;

`ifdef CHISELWATT_LOCK_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    // The counter only has to reach the largest terminal count it is used
    // for; the lock timeout only contributes when the timeout is built in.
    localparam int unsigned MAX_PH   = (PLL_RST_CYCLES > HOLD_CYCLES) ? PLL_RST_CYCLES : HOLD_CYCLES;
    localparam int unsigned CNT_MAX  = (TIMEOUT_EN && (LOCK_TIMEOUT > MAX_PH)) ? LOCK_TIMEOUT : MAX_PH;
    localparam int unsigned CNT_W    = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    // Terminal counts: the counter starts at 0 on state entry, so a phase of
    // N cycles ends when the counter holds N-1.
    localparam logic [CNT_W-1:0] PLL_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
`ifdef CHISELWATT_LOCK_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
`endif

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [7:0]             relock_q, relock_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    logic                   pll_rst_q, core_rst_q, ready_q;

    // Lock synchronizer: bit 0 is the metastability-exposed flop.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], lock};
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_PLL_RST;
            cnt_q      <= '0;
            relock_q   <= '0;
            pll_rst_q  <= 1'b1;
            core_rst_q <= 1'b1;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            relock_q   <= relock_d;
            // Outputs are registered from the next state so they line up
            // with state_q while staying free of any input-to-output path.
            pll_rst_q  <= (state_d == S_PLL_RST);
            core_rst_q <= (state_d != S_RUN);
            ready_q    <= (state_d == S_RUN);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        relock_d = relock_q;

        case (state_q)
            S_PLL_RST: begin
                if (cnt_q == PLL_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
`ifdef CHISELWATT_LOCK_TIMEOUT_EN
                end else if (cnt_q == TO_LAST) begin
                    // Give up on this lock attempt; this is not a lock loss,
                    // so relock_count is left alone.
                    state_d = S_PLL_RST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end

            S_HOLD: begin
                // Any dip in lock restarts the stability window without
                // resetting the PLL.
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_RUN: begin
                // Lock loss takes priority; a coincident soft request is dropped.
                if (!lock_s) begin
                    state_d = S_PLL_RST;
                    cnt_d   = '0;
                    if (relock_q != 8'hFF) begin
                        relock_d = relock_q + 8'd1;
                    end
                end else if (soft_rst_req) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = S_PLL_RST;
                cnt_d   = '0;
            end
        endcase
    end

    assign pll_rst      = pll_rst_q;
    assign core_rst     = core_rst_q;
    assign ready        = ready_q;
    assign relock_count = relock_q;
    assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_chiselwatt_reset_seq.sv
// ----------------------------------------------------------------------------
// tb_chiselwatt_reset_seq
//
// Directed bench for chiselwatt_reset_seq with SYNC_STAGES=2,
// PLL_RST_CYCLES=4, HOLD_CYCLES=8, LOCK_TIMEOUT=32. Inputs change 1 time
// unit after a rising edge; outputs are sampled at that same point, so a
// value seen "after edge e" is the registered result of edge e.
// Expected timing, hand-derived: a lock change made after edge L is seen by
// the FSM at edge L+3 (two synchronizer flops, then the state register).
// ----------------------------------------------------------------------------
module tb_chiselwatt_reset_seq;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       lock;
    logic       soft_rst_req;
    logic       pll_rst;
    logic       core_rst;
    logic       ready;
    logic [7:0] relock_count;
    logic [1:0] state_dbg;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [1:0] ST_PLL  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    chiselwatt_reset_seq #(
        .SYNC_STAGES   (2),
        .PLL_RST_CYCLES(4),
        .HOLD_CYCLES   (8),
        .LOCK_TIMEOUT  (32)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .lock         (lock),
        .soft_rst_req (soft_rst_req),
        .pll_rst      (pll_rst),
        .core_rst     (core_rst),
        .ready        (ready),
        .relock_count (relock_count),
        .state_dbg_o  (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reset for two edges, then release; the next rising edge is edge 1.
    task automatic apply_reset(input logic lock_v);
        reset_n      = 1'b0;
        soft_rst_req = 1'b0;
        lock         = lock_v;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // Lock high from release: lock_s after edge 2, WAIT after 4, HOLD after 5,
    // RUN after 13.
    task automatic bring_up();
        apply_reset(1'b1);
        repeat (13) tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [2:0] exp_o;
        reset_n      = 1'b1;
        lock         = 1'b0;
        soft_rst_req = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        // No clock edge yet: these values come from the asynchronous reset.
        n_cmp++; if ({pll_rst, core_rst, ready} !== 3'b110) begin n_bad++; $display("FAIL rst_async_outs: got %b want 110", {pll_rst, core_rst, ready}); end
        n_cmp++; if (relock_count !== 8'd0) begin n_bad++; $display("FAIL rst_async_relock: got %0d want 0", relock_count); end
        n_cmp++; if (state_dbg !== ST_PLL) begin n_bad++; $display("FAIL rst_async_state: got %0d want 0", state_dbg); end
        tick();
        n_cmp++; if ({pll_rst, state_dbg} !== {1'b1, ST_PLL}) begin n_bad++; $display("FAIL rst_held: got %b want 100", {pll_rst, state_dbg}); end
        reset_n = 1'b1;
        for (int e = 1; e <= 24; e++) begin
            tick();
            exp_o = {(e <= 3), !(e >= 21), (e >= 21)};
            n_cmp++; if ({pll_rst, core_rst, ready} !== exp_o) begin n_bad++; $display("FAIL bringup edge %0d: got %b want %b", e, {pll_rst, core_rst, ready}, exp_o); end
            if (e == 10) lock = 1'b1;
        end
        n_cmp++; if (relock_count !== 8'd0) begin n_bad++; $display("FAIL bringup_relock: got %0d want 0", relock_count); end
    endtask

    task automatic test_lock_loss();
        logic [2:0] exp_o;
        logic [7:0] exp_r;
        bring_up();
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL loss_pre_ready: got %b want 1", ready); end
        lock = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp_o = {(k >= 3 && k <= 6), (k >= 3 && k < 16), (k < 3 || k >= 16)};
            exp_r = (k >= 3) ? 8'd1 : 8'd0;
            n_cmp++; if ({pll_rst, core_rst, ready} !== exp_o) begin n_bad++; $display("FAIL loss k=%0d: got %b want %b", k, {pll_rst, core_rst, ready}, exp_o); end
            n_cmp++; if (relock_count !== exp_r) begin n_bad++; $display("FAIL loss_relock k=%0d: got %0d want %0d", k, relock_count, exp_r); end
            if (k == 7) begin n_cmp++; if (state_dbg !== ST_WAIT) begin n_bad++; $display("FAIL loss_wait: got %0d want 1", state_dbg); end end
            if (k == 8) begin n_cmp++; if (state_dbg !== ST_HOLD) begin n_bad++; $display("FAIL loss_hold: got %0d want 2", state_dbg); end end
            if (k == 5) lock = 1'b1;
        end
    endtask

    task automatic test_hold_glitch();
        logic [2:0] exp_o;
        apply_reset(1'b1);
        for (int e = 1; e <= 24; e++) begin
            tick();
            // Glitch after edge 7 lasting 3 cycles: WAIT after 10..12, HOLD
            // again after 13, RUN only a full 8 cycles later (edge 21).
            exp_o = {(e <= 3), !(e >= 21), (e >= 21)};
            n_cmp++; if ({pll_rst, core_rst, ready} !== exp_o) begin n_bad++; $display("FAIL glitch edge %0d: got %b want %b", e, {pll_rst, core_rst, ready}, exp_o); end
            if (e == 6)              begin n_cmp++; if (state_dbg !== ST_HOLD) begin n_bad++; $display("FAIL glitch_hold0: got %0d want 2", state_dbg); end end
            if (e >= 10 && e <= 12)  begin n_cmp++; if (state_dbg !== ST_WAIT) begin n_bad++; $display("FAIL glitch_wait edge %0d: got %0d want 1", e, state_dbg); end end
            if (e == 13)             begin n_cmp++; if (state_dbg !== ST_HOLD) begin n_bad++; $display("FAIL glitch_hold1: got %0d want 2", state_dbg); end end
            if (e == 7)  lock = 1'b0;
            if (e == 10) lock = 1'b1;
        end
        n_cmp++; if (relock_count !== 8'd0) begin n_bad++; $display("FAIL glitch_relock: got %0d want 0", relock_count); end
    endtask

    task automatic test_soft_reset();
        logic [2:0] exp_o;
        bring_up();
        soft_rst_req = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            // Second request at edge 5 lands in HOLD and must be ignored.
            exp_o = {1'b0, (k < 9), (k >= 9)};
            n_cmp++; if ({pll_rst, core_rst, ready} !== exp_o) begin n_bad++; $display("FAIL soft k=%0d: got %b want %b", k, {pll_rst, core_rst, ready}, exp_o); end
            if (k == 1) soft_rst_req = 1'b0;
            if (k == 4) soft_rst_req = 1'b1;
            if (k == 5) soft_rst_req = 1'b0;
        end
        n_cmp++; if (relock_count !== 8'd0) begin n_bad++; $display("FAIL soft_relock: got %0d want 0", relock_count); end
    endtask

    task automatic test_soft_vs_loss();
        logic [2:0] exp_o;
        bring_up();
        lock = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            tick();
            exp_o = {(k >= 3 && k <= 6), (k >= 3 && k < 16), (k < 3 || k >= 16)};
            n_cmp++; if ({pll_rst, core_rst, ready} !== exp_o) begin n_bad++; $display("FAIL softloss k=%0d: got %b want %b", k, {pll_rst, core_rst, ready}, exp_o); end
            if (k == 3) begin n_cmp++; if (relock_count !== 8'd1) begin n_bad++; $display("FAIL softloss_relock: got %0d want 1", relock_count); end end
            // Request coincides with the edge where lock_s is first low.
            if (k == 2) soft_rst_req = 1'b1;
            if (k == 3) begin soft_rst_req = 1'b0; lock = 1'b1; end
        end
    endtask

    task automatic test_timeout();
        logic exp_p;
        apply_reset(1'b0);
        for (int e = 1; e <= 80; e++) begin
            tick();
`ifdef CHISELWATT_LOCK_TIMEOUT_EN
            exp_p = (e <= 3) || (e >= 36 && e <= 39) || (e >= 72 && e <= 75);
`else
            exp_p = (e <= 3);
`endif
            n_cmp++; if ({pll_rst, ready} !== {exp_p, 1'b0}) begin n_bad++; $display("FAIL timeout edge %0d: got %b want %b", e, {pll_rst, ready}, {exp_p, 1'b0}); end
        end
        n_cmp++; if (relock_count !== 8'd0) begin n_bad++; $display("FAIL timeout_relock: got %0d want 0", relock_count); end
    endtask

    task automatic test_saturate_and_reset();
        logic got;
        bring_up();
        for (int i = 1; i <= 300; i++) begin
            lock = 1'b0;
            tick();
            lock = 1'b1;
            tick();
            tick();
            got = 1'b0;
            for (int w = 0; w < 40 && !got; w++) begin
                tick();
                if (ready === 1'b1) got = 1'b1;
            end
            if (!got) begin
                n_cmp++; n_bad++;
                $display("FAIL sat_ready_timeout loss %0d: ready %b want 1 within 40 cycles", i, ready);
                break;
            end
            if (i == 254) begin n_cmp++; if (relock_count !== 8'd254) begin n_bad++; $display("FAIL sat_254: got %0d want 254", relock_count); end end
            if (i == 255) begin n_cmp++; if (relock_count !== 8'd255) begin n_bad++; $display("FAIL sat_255: got %0d want 255", relock_count); end end
        end
        n_cmp++; if (relock_count !== 8'd255) begin n_bad++; $display("FAIL sat_final: got %0d want 255", relock_count); end

        // One more loss, then reset asynchronously in the middle of HOLD.
        lock = 1'b0;
        tick();
        lock = 1'b1;
        repeat (9) tick();
        n_cmp++; if (state_dbg !== ST_HOLD) begin n_bad++; $display("FAIL midhold_state: got %0d want 2", state_dbg); end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if ({pll_rst, core_rst, ready} !== 3'b110) begin n_bad++; $display("FAIL midhold_rst_outs: got %b want 110", {pll_rst, core_rst, ready}); end
        n_cmp++; if (relock_count !== 8'd0) begin n_bad++; $display("FAIL midhold_rst_relock: got %0d want 0", relock_count); end
        n_cmp++; if (state_dbg !== ST_PLL) begin n_bad++; $display("FAIL midhold_rst_state: got %0d want 0", state_dbg); end
        tick();
        reset_n = 1'b1;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_lock_loss();
        test_hold_glitch();
        test_soft_reset();
        test_soft_vs_loss();
        test_timeout();
        test_saturate_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
